// File: rtl/dcache_pkg.sv
// Shared types and constants for the write-through data cache.
// Holds the controller state encoding, the load/store size codes, the
// default geometry and the helpers that turn geometry into field widths.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Access size / signedness codes carried on funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int unsigned DEF_WIDTH          = 32;
  localparam int unsigned DEF_LINES          = 16;
  localparam int unsigned DEF_WORDS_PER_LINE = 4;
  localparam int unsigned BYTE_OFF_W         = 2;

  // Width of the line index field
  function automatic int unsigned idx_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Width of the word-within-line field
  function automatic int unsigned word_bits(input int unsigned words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// Byte-lane steering for the data cache (purely combinational).
// Ports:
//   i_funct3 - access size/signedness
//   i_off    - byte offset within the word (addr[1:0])
//   i_word   - cached word being loaded from
//   i_wdata  - right-aligned store data from the CPU
//   o_load   - extracted, sign/zero-extended load data
//   o_wdata  - store data replicated across byte lanes
//   o_wstrb  - store byte enables
module dcache_lane_align
  import dcache_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection; halves use addr[1] only
  always_comb begin
    w_byte = i_word[7:0];
    case (i_off)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
  end

  // Load extension
  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_load = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_load = {24'd0, w_byte};
      F3_LHU:  o_load = {16'd0, w_half};
      F3_LW:   o_load = i_word;
      default: o_load = i_word;
    endcase
  end

  // Store strobe and lane replication
  always_comb begin
    o_wstrb = 4'b1111;
    o_wdata = i_wdata;
    case (i_funct3)
      F3_LB, F3_LBU: begin
        o_wstrb = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_LH, F3_LHU: begin
        o_wstrb = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   req_valid_m/we_m/addr_m/wdata_m/funct3_m - memory-stage request
//   rdata_m                  - extended load data (same cycle on a hit)
//   stall_m                  - freezes the pipeline during refill/write
//   mem_req_valid/ready, mem_we, mem_addr, mem_wdata, mem_wstrb - memory request
//   mem_rvalid, mem_rdata    - memory read return
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int unsigned WIDTH          = DEF_WIDTH,
  parameter int unsigned LINES          = DEF_LINES,
  parameter int unsigned WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_m,
  input  logic             we_m,
  input  logic [WIDTH-1:0] addr_m,
  input  logic [WIDTH-1:0] wdata_m,
  input  logic [2:0]       funct3_m,
  output logic [WIDTH-1:0] rdata_m,
  output logic             stall_m,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int unsigned WORD_W = word_bits(WORDS_PER_LINE);
  localparam int unsigned IDX_W  = idx_bits(LINES);
  localparam int unsigned OB     = BYTE_OFF_W + WORD_W;
  localparam int unsigned TAG_W  = WIDTH - OB - IDX_W;

  state_t              r_state;
  logic [LINES-1:0]    r_valid;
  logic [WORD_W-1:0]   r_cnt;
  logic [TAG_W-1:0]    r_tag  [LINES];
  logic [WIDTH-1:0]    r_data [LINES][WORDS_PER_LINE];

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_W-1:0]    w_idx;
  logic [WORD_W-1:0]   w_wsel;
  logic [WORD_W-1:0]   w_cnt_nxt;
  logic                w_hit;
  logic                w_last;
  logic [WIDTH-1:0]    w_word;
  logic [WIDTH-1:0]    w_load;
  logic [WIDTH-1:0]    w_st_data;
  logic [3:0]          w_st_strb;

  assign w_tag     = addr_m[WIDTH-1 -: TAG_W];
  assign w_idx     = addr_m[OB +: IDX_W];
  assign w_wsel    = addr_m[BYTE_OFF_W +: WORD_W];
  assign w_cnt_nxt = r_cnt + WORD_W'(1);
  assign w_last    = (r_cnt == WORD_W'(WORDS_PER_LINE - 1));
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_word    = r_data[w_idx][w_wsel];

  dcache_lane_align u_align (
    .i_funct3 (funct3_m),
    .i_off    (addr_m[1:0]),
    .i_word   (w_word),
    .i_wdata  (wdata_m),
    .o_load   (w_load),
    .o_wdata  (w_st_data),
    .o_wstrb  (w_st_strb)
  );

  assign rdata_m = (req_valid_m && !we_m && w_hit) ? w_load : '0;

  // Stall is raised in the request cycle itself; reset drops it at once
  always_comb begin
    stall_m = 1'b0;
    if (!rst) begin
      if (r_state == IDLE) stall_m = req_valid_m && (we_m || !w_hit);
      else                 stall_m = (r_state != RESP);
    end
  end

  // Controller with registered memory-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_valid       <= '0;
      r_cnt         <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid_m) begin
            if (we_m) begin
              r_state       <= WR_REQ;
              mem_req_valid <= 1'b1;
              mem_we        <= 1'b1;
              mem_addr      <= {addr_m[WIDTH-1:2], 2'b00};
              mem_wdata     <= w_st_data;
              mem_wstrb     <= w_st_strb;
            end else if (!w_hit) begin
              // Line is invalid while partially filled
              r_state        <= RD_REQ;
              r_valid[w_idx] <= 1'b0;
              r_cnt          <= '0;
              mem_req_valid  <= 1'b1;
              mem_we         <= 1'b0;
              mem_addr       <= {w_tag, w_idx, {OB{1'b0}}};
              mem_wdata      <= '0;
              mem_wstrb      <= '0;
            end
          end
        end
        RD_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_state       <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (mem_rvalid) begin
            if (w_last) begin
              r_valid[w_idx] <= 1'b1;
              r_state        <= RESP;
            end else begin
              r_cnt         <= w_cnt_nxt;
              mem_req_valid <= 1'b1;
              mem_addr      <= {w_tag, w_idx, w_cnt_nxt, 2'b00};
              r_state       <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_wstrb     <= '0;
            r_state       <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays: refill words, and store-hit lane updates on accept
  always_ff @(posedge clk) begin
    if (r_state == RD_WAIT && mem_rvalid) begin
      r_data[w_idx][r_cnt] <= mem_rdata;
      if (w_last) r_tag[w_idx] <= w_tag;
    end
    if (r_state == WR_REQ && mem_req_ready && w_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) r_data[w_idx][w_wsel][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule
